// File: rtl/uart_rx_pkg.sv
// Shared constants and FSM encoding for the 8N1 receiver.
// Holds baud divider values, frame length and state type.
package uart_rx_pkg;

    localparam int unsigned B115200  = 104;
    localparam int unsigned B57600   = 208;
    localparam int unsigned B9600    = 1250;
    localparam int unsigned FrameLen = 10;

    typedef enum logic [1:0] {
        StIdle,
        StRecv,
        StLoad,
        StDav
    } state_e;

    // Bit index of the stop bit; the bit counter saturates here.
    localparam logic [3:0] LastBit = 4'(FrameLen - 1);

    function automatic logic [3:0] bit_cnt_inc(input logic [3:0] cnt);
        return (cnt >= LastBit) ? LastBit : cnt + 4'd1;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Serial line and received-byte outputs of the UART receiver.
// master drives the line and observes the outputs; slave is the receiver.
interface uart_rx_if;

    logic       rx;
    logic [7:0] data;
    logic       rcv;
    logic       ferr;

    modport master (
        output rx,
        input  data,
        input  rcv,
        input  ferr
    );

    modport slave (
        input  rx,
        output data,
        output rcv,
        output ferr
    );

endinterface

// File: rtl/baudgen_rx.sv
// Receive-side bit tick generator: first tick Baud/2 cycles after enable,
// then every Baud cycles; dropping clk_ena clears the counter.
module baudgen_rx #(
    parameter int unsigned Baud = 104
) (
    input  logic clk,
    input  logic rst,
    input  logic clk_ena,
    output logic clk_out
);

    localparam int unsigned CntW = (Baud > 2) ? $clog2(Baud) : 1;
    localparam logic [CntW-1:0] HalfTop = CntW'(Baud / 2 - 1);
    localparam logic [CntW-1:0] FullTop = CntW'(Baud - 1);

    logic [CntW-1:0] cnt_d, cnt_q;
    logic            first_d, first_q;
    logic            hit;

    // The first interval is half a bit so sampling lands mid-bit.
    assign hit = (cnt_q == (first_q ? HalfTop : FullTop));

    always_comb begin
        cnt_d   = cnt_q;
        first_d = first_q;
        if (!clk_ena) begin
            cnt_d   = '0;
            first_d = 1'b1;
        end else if (hit) begin
            cnt_d   = '0;
            first_d = 1'b0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign clk_out = clk_ena && hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            first_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            first_q <= first_d;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling, one-cycle rcv strobe.
// Define UART_RX_FERR_EN to check the stop bit and report framing errors on ferr.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned Baud = B115200
) (
    input logic       clk,
    input logic       rst,
    uart_rx_if.slave  bus
);

    logic       rx_meta_q, rx_s_q;
    state_e     state_d, state_q;
    logic [3:0] bit_cnt_d, bit_cnt_q;
    logic [7:0] shift_d, shift_q;
    logic [7:0] data_d, data_q;
    logic       baud_ena, tick;
    logic       frame_ok;

    baudgen_rx #(
        .Baud (Baud)
    ) u_baudgen (
        .clk     (clk),
        .rst     (rst),
        .clk_ena (baud_ena),
        .clk_out (tick)
    );

`ifdef UART_RX_FERR_EN
    logic stop_d, stop_q;

    always_comb begin
        stop_d = stop_q;
        if (state_q == StRecv && tick && bit_cnt_q == LastBit) begin
            stop_d = rx_s_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stop_q <= 1'b0;
        end else begin
            stop_q <= stop_d;
        end
    end

    assign frame_ok = stop_q;
`else
    assign frame_ok = 1'b1;
`endif

    // Datapath next-state: bit counter, shift register, output byte.
    always_comb begin
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        data_d    = data_q;
        unique case (state_q)
            StIdle: begin
                if (!rx_s_q) begin
                    bit_cnt_d = '0;
                end
            end
            StRecv: begin
                if (tick) begin
                    bit_cnt_d = bit_cnt_inc(bit_cnt_q);
                    if (bit_cnt_q >= 4'd1 && bit_cnt_q <= 4'd8) begin
                        shift_d = {rx_s_q, shift_q[7:1]};
                    end
                end
            end
            StLoad: begin
                if (frame_ok) begin
                    data_d = shift_q;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (!rx_s_q) state_d = StRecv;
            StRecv: begin
                if (tick) begin
                    if (bit_cnt_q == 4'd0 && rx_s_q) begin
                        state_d = StIdle;
                    end else if (bit_cnt_q == LastBit) begin
                        state_d = StLoad;
                    end
                end
            end
            StLoad: state_d = StDav;
            StDav:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        baud_ena = (state_q == StRecv);
        bus.rcv  = (state_q == StDav) && frame_ok;
        bus.ferr = (state_q == StDav) && !frame_ok;
    end

    assign bus.data = data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
        end else begin
            rx_meta_q <= bus.rx;
            rx_s_q    <= rx_meta_q;
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
        end
    end

endmodule
